// File: rtl/uart_imem_loader.sv
// uart_imem_loader
// Receives a program over an 8N1 UART line and writes it, one little-endian
// 32-bit word at a time, into instruction memory. Loading ends either on the
// end-of-program marker word or when the last memory address has been
// written; prog_done_o then stays high until reset and releases the core.
//
// Write port semantics: imem_we_o is a one-cycle strobe with no back-pressure.
// imem_addr_o and imem_wdata_o are valid and stable in any cycle where
// imem_we_o is high. The memory must accept the write in that cycle.

module uart_imem_loader #(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_WIDTH   = 8,
    parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  prog_done_o,
    output logic                  frame_err_o,
    output logic [ADDR_WIDTH:0]   word_count_o
);

    // Bit-period counter only ever reaches CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

    // RX FSM encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STOP    = 3'd3;
    localparam logic [2:0] ST_CLEANUP = 3'd4;

    // ------------------------------------------------------------------
    // Serial input synchronizer
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    // Two-flop synchronizer; flops reset to the idle (high) line level so
    // reset release is not seen as a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    logic [2:0]       rx_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_valid;

    // RX FSM: start-bit qualification at mid-bit, then one sample per bit
    // period for 8 data bits and the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state    <= ST_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            rx_shift    <= '0;
            byte_valid  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_err_o <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_sync) begin
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_cnt == HALF_CNT) begin
                        bit_cnt <= '0;
                        // A line that is already high again was a glitch.
                        rx_state <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= ST_STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_cnt == LAST_CNT) begin
                        bit_cnt <= '0;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            // Error reporting freezes with the other outputs
                            // once the program is loaded.
                            frame_err_o <= ~prog_done_o;
                        end
                        rx_state <= ST_CLEANUP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_CLEANUP: begin
                    rx_state <= ST_IDLE;
                end
                default: begin
                    rx_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Word assembly
    // ------------------------------------------------------------------
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;
    logic        word_ready;

    // Little-endian packing of good bytes; dropped (bad-stop) bytes never
    // reach here, so they do not advance the byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= '0;
            word_buf   <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (byte_valid && !prog_done_o) begin
                word_buf[{byte_idx, 3'b000} +: 8] <= rx_shift;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    word_ready <= 1'b1;
                end
            end
        end
    end

    // The assembly buffer holds still for the whole write cycle (the next
    // byte is at least a frame away), so it drives the write data directly.
    assign imem_wdata_o = word_buf;

    // ------------------------------------------------------------------
    // Memory write and completion
    // ------------------------------------------------------------------

    // Commit a completed word: marker ends the load, anything else is written.
    // Address and count advance at the end of the write cycle; writing the
    // last address ends the load without wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            word_count_o <= '0;
            prog_done_o  <= 1'b0;
        end else begin
            imem_we_o <= 1'b0;
            if (imem_we_o) begin
                word_count_o <= word_count_o + (ADDR_WIDTH + 1)'(1);
                if (imem_addr_o == ADDR_MAX) begin
                    prog_done_o <= 1'b1;
                end else begin
                    imem_addr_o <= imem_addr_o + ADDR_WIDTH'(1);
                end
            end else if (word_ready && !prog_done_o) begin
                if (word_buf == END_WORD) begin
                    prog_done_o <= 1'b1;
                end else begin
                    imem_we_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Testbench for uart_imem_loader: two instances (256-word and 4-word memory)
// share one serial line; a byte-level model predicts the writes of each.

module tb_uart_imem_loader;

    localparam int          CPB      = 16;
    localparam logic [31:0] END_WORD = 32'h0000_0FFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic        we8, done8, ferr8;
    logic [7:0]  addr8;
    logic [31:0] wdata8;
    logic [8:0]  cnt8;

    logic        we2, done2, ferr2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  cnt2;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8), .END_WORD(END_WORD)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .rx_i(rx),
        .imem_we_o(we8), .imem_addr_o(addr8), .imem_wdata_o(wdata8),
        .prog_done_o(done8), .frame_err_o(ferr8), .word_count_o(cnt8)
    );

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(2), .END_WORD(END_WORD)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .rx_i(rx),
        .imem_we_o(we2), .imem_addr_o(addr2), .imem_wdata_o(wdata2),
        .prog_done_o(done2), .frame_err_o(ferr2), .word_count_o(cnt2)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;

    // entries are {8-bit address, 32-bit data}
    logic [39:0] exp8_q[$];
    logic [39:0] exp2_q[$];
    logic [39:0] obs8_q[$];
    logic [39:0] obs2_q[$];
    int ferr_cnt[2];

    // Monitor samples on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (we8) obs8_q.push_back({addr8, wdata8});
        if (we2) obs2_q.push_back({6'd0, addr2, wdata2});
        if (ferr8) ferr_cnt[0]++;
        if (ferr2) ferr_cnt[1]++;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_word[2];
    int          m_idx[2];
    int          m_count[2];
    bit          m_done[2];
    int          m_depth[2] = '{256, 4};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_word[d]   = '0;
            m_idx[d]    = 0;
            m_count[d]  = 0;
            m_done[d]   = 1'b0;
            ferr_cnt[d] = 0;
        end
        exp8_q.delete();
        exp2_q.delete();
        obs8_q.delete();
        obs2_q.delete();
    endtask

    // One correctly framed byte: pack into word, every 4th byte completes it.
    task automatic model_byte(input logic [7:0] b);
        logic [39:0] e;
        for (int d = 0; d < 2; d++) begin
            if (!m_done[d]) begin
                m_word[d][8*m_idx[d] +: 8] = b;
                m_idx[d]++;
                if (m_idx[d] == 4) begin
                    m_idx[d] = 0;
                    if (m_word[d] == END_WORD) begin
                        m_done[d] = 1'b1;
                    end else begin
                        e = {m_count[d][7:0], m_word[d]};
                        if (d == 0) exp8_q.push_back(e);
                        else        exp2_q.push_back(e);
                        m_count[d]++;
                        if (m_count[d] == m_depth[d]) m_done[d] = 1'b1;
                    end
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        model_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_good(w[8*k +: 8]);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w == END_WORD) w = w ^ 32'h1;
        return w;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({we8, addr8, wdata8, done8, ferr8, cnt8} !== 52'd0) begin
            errors++;
            $display("FAIL reset_dut8 got=%h exp=0", {we8, addr8, wdata8, done8, ferr8, cnt8});
        end
        checks++;
        if ({we2, addr2, wdata2, done2, ferr2, cnt2} !== 40'd0) begin
            errors++;
            $display("FAIL reset_dut2 got=%h exp=0", {we2, addr2, wdata2, done2, ferr2, cnt2});
        end
    endtask

    task automatic test_single_word();
        apply_reset();
        send_word(32'h0000_0013);
        send_word(END_WORD);
        checks++;
        if (obs8_q.size() != 1) begin
            errors++;
            $display("FAIL single_nwrites got=%0d exp=1", obs8_q.size());
        end else begin
            checks++;
            if (obs8_q[0] !== {8'h00, 32'h0000_0013}) begin
                errors++;
                $display("FAIL single_write got=%h exp=%h", obs8_q[0], {8'h00, 32'h0000_0013});
            end
        end
        checks++;
        if (done8 !== 1'b1 || cnt8 !== 9'd1) begin
            errors++;
            $display("FAIL single_done_cnt got=%b/%0d exp=1/1", done8, cnt8);
        end
    endtask

    task automatic test_three_words();
        logic [31:0] words[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        apply_reset();
        for (int i = 0; i < 3; i++) send_word(words[i]);
        send_word(END_WORD);
        checks++;
        if (obs8_q.size() != 3) begin
            errors++;
            $display("FAIL three_nwrites got=%0d exp=3", obs8_q.size());
        end
        for (int i = 0; i < 3 && i < obs8_q.size(); i++) begin
            checks++;
            if (obs8_q[i] !== {i[7:0], words[i]}) begin
                errors++;
                $display("FAIL three_write%0d got=%h exp=%h", i, obs8_q[i], {i[7:0], words[i]});
            end
        end
        checks++;
        if (done8 !== 1'b1 || done2 !== 1'b1 || cnt2 !== 3'd3) begin
            errors++;
            $display("FAIL three_done got=%b/%b/%0d exp=1/1/3", done8, done2, cnt2);
        end
    endtask

    task automatic test_random_words();
        int n;
        apply_reset();
        n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) send_word(rand_word());
        send_word(END_WORD);
        checks++;
        if (obs8_q.size() != exp8_q.size() || obs2_q.size() != exp2_q.size()) begin
            errors++;
            $display("FAIL rand_nwrites got=%0d/%0d exp=%0d/%0d",
                     obs8_q.size(), obs2_q.size(), exp8_q.size(), exp2_q.size());
        end
        for (int i = 0; i < exp8_q.size() && i < obs8_q.size(); i++) begin
            checks++;
            if (obs8_q[i] !== exp8_q[i]) begin
                errors++;
                $display("FAIL rand_write8_%0d got=%h exp=%h", i, obs8_q[i], exp8_q[i]);
            end
        end
        for (int i = 0; i < exp2_q.size() && i < obs2_q.size(); i++) begin
            checks++;
            if (obs2_q[i] !== exp2_q[i]) begin
                errors++;
                $display("FAIL rand_write2_%0d got=%h exp=%h", i, obs2_q[i], exp2_q[i]);
            end
        end
        checks++;
        if (done8 !== m_done[0] || done2 !== m_done[1] ||
            int'(cnt8) != m_count[0] || int'(cnt2) != m_count[1]) begin
            errors++;
            $display("FAIL rand_status got=%b/%b/%0d/%0d exp=%b/%b/%0d/%0d",
                     done8, done2, cnt8, cnt2, m_done[0], m_done[1], m_count[0], m_count[1]);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] b[4];
        apply_reset();
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom());
        if ({b[3], b[2], b[1], b[0]} == END_WORD) b[3] = 8'h5A;
        send_good(b[0]);
        send_byte(b[1], 1'b0);
        checks++;
        if (ferr_cnt[0] != 1 || ferr_cnt[1] != 1 || obs8_q.size() != 0) begin
            errors++;
            $display("FAIL ferr_pulse got=%0d/%0d writes=%0d exp=1/1 writes=0",
                     ferr_cnt[0], ferr_cnt[1], obs8_q.size());
        end
        for (int i = 1; i < 4; i++) send_good(b[i]);
        send_word(END_WORD);
        checks++;
        if (obs8_q.size() != 1 || ferr_cnt[0] != 1) begin
            errors++;
            $display("FAIL ferr_resend got=%0d writes ferr=%0d exp=1 writes ferr=1",
                     obs8_q.size(), ferr_cnt[0]);
        end else begin
            checks++;
            if (obs8_q[0] !== {8'h00, b[3], b[2], b[1], b[0]}) begin
                errors++;
                $display("FAIL ferr_word got=%h exp=%h", obs8_q[0], {8'h00, b[3], b[2], b[1], b[0]});
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] w;
        apply_reset();
        w = rand_word();
        send_good(w[7:0]);
        rx = 1'b0;
        repeat ((CPB * 3) / 10) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        checks++;
        if (ferr_cnt[0] != 0 || obs8_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_quiet got=ferr %0d writes %0d exp=0 0", ferr_cnt[0], obs8_q.size());
        end
        for (int k = 1; k < 4; k++) send_good(w[8*k +: 8]);
        checks++;
        if (obs8_q.size() != 1) begin
            errors++;
            $display("FAIL glitch_nwrites got=%0d exp=1", obs8_q.size());
        end else begin
            checks++;
            if (obs8_q[0] !== {8'h00, w}) begin
                errors++;
                $display("FAIL glitch_word got=%h exp=%h", obs8_q[0], {8'h00, w});
            end
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 5; i++) send_word(rand_word());
        checks++;
        if (obs2_q.size() != 4 || done2 !== 1'b1 || cnt2 !== 3'd4 || addr2 !== 2'd3) begin
            errors++;
            $display("FAIL full_dut2 got=%0d writes done=%b cnt=%0d addr=%0d exp=4 1 4 3",
                     obs2_q.size(), done2, cnt2, addr2);
        end
        for (int i = 0; i < 4 && i < obs2_q.size(); i++) begin
            checks++;
            if (obs2_q[i] !== exp2_q[i] || obs2_q[i][33:32] !== 2'(i)) begin
                errors++;
                $display("FAIL full_write%0d got=%h exp=%h", i, obs2_q[i], exp2_q[i]);
            end
        end
        checks++;
        if (obs8_q.size() != 5 || done8 !== 1'b0 || cnt8 !== 9'd5) begin
            errors++;
            $display("FAIL full_dut8 got=%0d writes done=%b cnt=%0d exp=5 0 5",
                     obs8_q.size(), done8, cnt8);
        end
    endtask

    // Runs straight after test_full so counters are non-zero going in.
    task automatic test_reset_mid_word();
        logic [31:0] w;
        send_good(8'hA5);
        send_good(8'h3C);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({we8, addr8, wdata8, done8, ferr8, cnt8} !== 52'd0 ||
            {we2, addr2, wdata2, done2, ferr2, cnt2} !== 40'd0) begin
            errors++;
            $display("FAIL midrst_async got=%h/%h exp=0/0",
                     {we8, addr8, wdata8, done8, ferr8, cnt8}, {we2, addr2, wdata2, done2, ferr2, cnt2});
        end
        repeat (3) @(posedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        w = rand_word();
        send_word(w);
        send_word(END_WORD);
        checks++;
        if (obs8_q.size() != 1 || done8 !== 1'b1 || cnt8 !== 9'd1) begin
            errors++;
            $display("FAIL midrst_nwrites got=%0d done=%b cnt=%0d exp=1 1 1", obs8_q.size(), done8, cnt8);
        end else begin
            checks++;
            if (obs8_q[0] !== {8'h00, w}) begin
                errors++;
                $display("FAIL midrst_word got=%h exp=%h", obs8_q[0], {8'h00, w});
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        model_reset();
        test_reset();
        test_single_word();
        test_three_words();
        test_random_words();
        test_frame_err();
        test_glitch();
        test_full();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
